// File: rtl/imem_pkg.sv
// Shared types and defaults for the fetch-stage instruction memory.
package imem_pkg;

  localparam logic [31:0] NOP_WORD_DEFAULT = 32'h0000_0013;

  typedef struct packed {
    logic out_of_range;
    logic misaligned;
  } fault_t;

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_t;

endpackage

// File: rtl/imem_if.sv
// Fetch request/response bus between the core front-end and the instruction memory.
interface imem_if #(
  parameter int XLEN = 32
) ();
  logic            req_valid;
  logic            req_ready;
  logic [XLEN-1:0] req_addr;
  logic            flush;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [XLEN-1:0] rsp_instr;
  logic [XLEN-1:0] rsp_addr;
  logic [1:0]      rsp_fault;

  modport master (
    output req_valid, req_addr, flush, rsp_ready,
    input  req_ready, rsp_valid, rsp_instr, rsp_addr, rsp_fault
  );

  modport slave (
    input  req_valid, req_addr, flush, rsp_ready,
    output req_ready, rsp_valid, rsp_instr, rsp_addr, rsp_fault
  );
endinterface

// File: rtl/imem_rsp_fifo.sv
// Two-entry response buffer; entries hold {instr, addr, fault} packed by the caller.
module imem_rsp_fifo #(
  parameter int W = 66
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] push_data,
  output logic [W-1:0] head,
  output logic         valid,
  output logic         full
);

  logic [W-1:0] ent_q [2];
  logic         wr_q;
  logic         rd_q;
  logic [1:0]   count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent_q[0] <= '0;
      ent_q[1] <= '0;
      wr_q     <= 1'b0;
      rd_q     <= 1'b0;
      count_q  <= 2'd0;
    end else if (flush) begin
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      count_q <= 2'd0;
    end else begin
      if (push) begin
        ent_q[wr_q] <= push_data;
        wr_q        <= ~wr_q;
      end
      if (pop) rd_q <= ~rd_q;
      case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign head  = ent_q[rd_q];
  assign valid = (count_q != 2'd0);
  assign full  = (count_q == 2'd2);

endmodule

// File: rtl/imem_pipelined.sv
// Word-addressed instruction memory with registered read, 2-deep response buffer,
// program-load port, fault decode and an optional post-reset NOP sweep.
//
//   state   | meaning
//   ST_INIT | sweeping NOP_WORD into every word, requests and loads blocked
//   ST_RUN  | serving fetches, load port active
module imem_pipelined
  import imem_pkg::*;
#(
  parameter int              XLEN           = 32,
  parameter int              DEPTH          = 1024,
  parameter logic [XLEN-1:0] BASE_ADDR      = '0,
  parameter logic [XLEN-1:0] NOP_WORD       = NOP_WORD_DEFAULT,
  parameter bit              CLEAR_ON_RESET = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  imem_if.slave                    bus,
  input  logic                     load_en,
  input  logic [$clog2(DEPTH)-1:0] load_idx,
  input  logic [XLEN-1:0]          load_data,
  output logic                     init_busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = 2 * XLEN + 2;

  state_t          state_q, state_d;
  logic [AW-1:0]   ctr_q;
  logic [XLEN-1:0] mem [DEPTH];

  logic [XLEN-1:0] offs;
  logic [AW-1:0]   idx;
  fault_t          fault;
  logic [XLEN-1:0] rd_word;

  logic            run;
  logic            mem_we;
  logic [AW-1:0]   mem_wa;
  logic [XLEN-1:0] mem_wd;

  logic            accept;
  logic            fifo_valid;
  logic            fifo_full;
  logic [EW-1:0]   push_data;
  logic [EW-1:0]   head;

  // Addresses below BASE_ADDR wrap to huge offsets and land in out_of_range.
  assign offs               = bus.req_addr - BASE_ADDR;
  assign idx                = offs[AW+1:2];
  assign fault.misaligned   = (bus.req_addr[1:0] != 2'b00);
  assign fault.out_of_range = ((offs >> (AW + 2)) != '0);
  assign rd_word            = (|fault) ? NOP_WORD : mem[idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CLEAR_ON_RESET ? ST_INIT : ST_RUN;
      ctr_q   <= '0;
    end else begin
      state_q <= state_d;
      ctr_q   <= (state_q == ST_INIT) ? ctr_q + 1'b1 : '0;
    end
  end

  always_comb begin
    state_d   = state_q;
    run       = 1'b0;
    init_busy = 1'b0;
    mem_we    = 1'b0;
    mem_wa    = load_idx;
    mem_wd    = load_data;
    case (state_q)
      ST_INIT: begin
        init_busy = 1'b1;
        mem_we    = 1'b1;
        mem_wa    = ctr_q;
        mem_wd    = NOP_WORD;
        if (ctr_q == AW'(DEPTH - 1)) state_d = ST_RUN;
      end
      ST_RUN: begin
        run    = 1'b1;
        mem_we = load_en;
      end
      default: state_d = ST_RUN;
    endcase
  end

  // Read is taken combinationally into the FIFO at the same edge as any write,
  // so a same-index load is seen by the following request, not this one.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_wa] <= mem_wd;
  end

  assign bus.req_ready = run && !fifo_full;
  assign accept        = bus.req_valid && bus.req_ready && !bus.flush;
  assign push_data     = {rd_word, bus.req_addr, fault};

  imem_rsp_fifo #(.W(EW)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (bus.flush),
    .push      (accept),
    .pop       (fifo_valid && bus.rsp_ready),
    .push_data (push_data),
    .head      (head),
    .valid     (fifo_valid),
    .full      (fifo_full)
  );

  assign bus.rsp_valid = fifo_valid;
  assign bus.rsp_instr = head[EW-1 -: XLEN];
  assign bus.rsp_addr  = head[XLEN+1 -: XLEN];
  assign bus.rsp_fault = head[1:0];

endmodule

// File: tb/tb_imem_pipelined.sv
// Directed bench for imem_pipelined: sweep, streaming, backpressure, faults, flush, load hazard, reset.
module tb_imem_pipelined;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n0, rst_n1;
  logic       load_en0, load_en1;
  logic [9:0] load_idx0, load_idx1;
  logic [31:0] load_data0, load_data1;
  logic       init_busy0, init_busy1;

  imem_if #(.XLEN(32)) bif0 ();
  imem_if #(.XLEN(32)) bif1 ();

  imem_pipelined #(.CLEAR_ON_RESET(1'b1)) u_dut0 (
    .clk(clk), .rst_n(rst_n0), .bus(bif0),
    .load_en(load_en0), .load_idx(load_idx0), .load_data(load_data0),
    .init_busy(init_busy0)
  );

  imem_pipelined #(.CLEAR_ON_RESET(1'b0)) u_dut1 (
    .clk(clk), .rst_n(rst_n1), .bus(bif1),
    .load_en(load_en1), .load_idx(load_idx1), .load_data(load_data1),
    .init_busy(init_busy1)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] instr;
    logic [1:0]  fault;
  } vec_t;

  vec_t        vecs[8];
  logic [31:0] aw[6];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic load0(input logic [9:0] idx, input logic [31:0] data);
    load_en0 = 1'b1; load_idx0 = idx; load_data0 = data;
    cyc();
    load_en0 = 1'b0;
  endtask

  task automatic read0(input logic [31:0] addr, output logic [31:0] instr,
                       output logic [31:0] raddr, output logic [1:0] fault, output logic ok);
    ok = 1'b0; instr = '0; raddr = '0; fault = '0;
    bif0.rsp_ready = 1'b1;
    bif0.req_valid = 1'b1;
    bif0.req_addr  = addr;
    for (int w = 0; w < 50 && !bif0.req_ready; w++) cyc();
    if (bif0.req_ready) begin
      cyc();
      bif0.req_valid = 1'b0;
      ok    = bif0.rsp_valid;
      instr = bif0.rsp_instr;
      raddr = bif0.rsp_addr;
      fault = bif0.rsp_fault;
      cyc();
    end
    bif0.req_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] ri, ra;
    logic [1:0]  rf;
    logic        rok;
    int          cycles, bad_rdy, sent, seen;
    logic [31:0] got[$];

    for (int i = 0; i < 6; i++) aw[i] = 32'hA5A5_0000 + 32'(i * 32'h111);
    vecs[0] = '{32'h0000_0010, NOP,   2'b00};
    vecs[1] = '{32'h0000_0FFC, NOP,   2'b00};
    vecs[2] = '{32'h0000_0000, aw[0], 2'b00};
    vecs[3] = '{32'h0000_000C, aw[3], 2'b00};
    vecs[4] = '{32'h0000_0006, NOP,   2'b01};
    vecs[5] = '{32'h0000_1000, NOP,   2'b10};
    vecs[6] = '{32'h0000_1002, NOP,   2'b11};
    vecs[7] = '{32'hFFFF_FFFC, NOP,   2'b10};

    rst_n0 = 1'b0; rst_n1 = 1'b0;
    load_en0 = 1'b0; load_idx0 = '0; load_data0 = '0;
    load_en1 = 1'b0; load_idx1 = '0; load_data1 = '0;
    bif0.req_valid = 1'b0; bif0.req_addr = '0; bif0.flush = 1'b0; bif0.rsp_ready = 1'b0;
    bif1.req_valid = 1'b0; bif1.req_addr = '0; bif1.flush = 1'b0; bif1.rsp_ready = 1'b0;

    repeat (3) cyc();
    chk("rst_rsp_valid", 64'(bif0.rsp_valid), 64'd0);
    chk("rst_rsp_instr", 64'(bif0.rsp_instr), 64'd0);
    chk("rst_rsp_fault", 64'(bif0.rsp_fault), 64'd0);
    rst_n0 = 1'b1;

    // NOP sweep length and request blocking
    cycles = 0; bad_rdy = 0;
    while (init_busy0 && cycles < 2000) begin
      if (bif0.req_ready) bad_rdy++;
      cycles++;
      cyc();
    end
    chk("init_len", 64'(cycles), 64'd1024);
    chk("init_ready_low", 64'(bad_rdy), 64'd0);
    chk("run_ready", 64'(bif0.req_ready), 64'd1);

    read0(32'h0, ri, ra, rf, rok);
    chk("swept_ok", 64'(rok), 64'd1);
    chk("swept_instr", 64'(ri), 64'(NOP));

    for (int i = 0; i < 4; i++) load0(10'(i), aw[i]);

    foreach (vecs[i]) begin
      read0(vecs[i].addr, ri, ra, rf, rok);
      chk($sformatf("vec%0d_latency", i), 64'(rok), 64'd1);
      chk($sformatf("vec%0d_instr", i), 64'(ri), 64'(vecs[i].instr));
      chk($sformatf("vec%0d_addr", i), 64'(ra), 64'(vecs[i].addr));
      chk($sformatf("vec%0d_fault", i), 64'(rf), 64'(vecs[i].fault));
    end

    // back-to-back stream, one response per cycle
    bif0.rsp_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bif0.req_valid = (i < 4);
      bif0.req_addr  = 32'(i * 4);
      if (i < 4) chk($sformatf("stream_ready%0d", i), 64'(bif0.req_ready), 64'd1);
      if (i == 0) chk("stream_idle", 64'(bif0.rsp_valid), 64'd0);
      else begin
        chk($sformatf("stream_valid%0d", i), 64'(bif0.rsp_valid), 64'd1);
        chk($sformatf("stream_instr%0d", i), 64'(bif0.rsp_instr), 64'(aw[i-1]));
        chk($sformatf("stream_addr%0d", i), 64'(bif0.rsp_addr), 64'((i - 1) * 4));
      end
      cyc();
    end
    bif0.req_valid = 1'b0;
    chk("stream_drained", 64'(bif0.rsp_valid), 64'd0);

    // backpressure: two fit, third waits
    bif0.rsp_ready = 1'b0;
    sent = 0;
    for (int c = 0; c < 4; c++) begin
      bif0.req_valid = 1'b1;
      bif0.req_addr  = 32'(sent * 4);
      if (bif0.req_ready) sent++;
      cyc();
    end
    chk("bp_accepted", 64'(sent), 64'd2);
    chk("bp_ready_low", 64'(bif0.req_ready), 64'd0);
    chk("bp_hold_valid", 64'(bif0.rsp_valid), 64'd1);
    chk("bp_hold_instr", 64'(bif0.rsp_instr), 64'(aw[0]));
    bif0.rsp_ready = 1'b1;
    got.delete();
    for (int c = 0; c < 20 && !(sent == 3 && got.size() == 3); c++) begin
      bif0.req_valid = (sent < 3);
      bif0.req_addr  = 32'(sent * 4);
      if (bif0.rsp_valid) got.push_back(bif0.rsp_instr);
      if (bif0.req_valid && bif0.req_ready) sent++;
      cyc();
    end
    bif0.req_valid = 1'b0;
    chk("bp_count", 64'(got.size()), 64'd3);
    for (int i = 0; i < 3; i++)
      if (i < got.size()) chk($sformatf("bp_order%0d", i), 64'(got[i]), 64'(aw[i]));
    chk("bp_empty", 64'(bif0.rsp_valid), 64'd0);

    // flush with full buffer
    bif0.rsp_ready = 1'b0;
    bif0.req_valid = 1'b1; bif0.req_addr = 32'h0; cyc();
    bif0.req_addr = 32'h4; cyc();
    bif0.req_addr = 32'h8; bif0.flush = 1'b1; cyc();
    bif0.flush = 1'b0; bif0.req_valid = 1'b0;
    chk("flush_valid", 64'(bif0.rsp_valid), 64'd0);
    chk("flush_ready", 64'(bif0.req_ready), 64'd1);
    // flush in the same cycle as an accepted request
    bif0.req_valid = 1'b1; bif0.req_addr = 32'h0; cyc();
    bif0.req_addr = 32'hC; bif0.flush = 1'b1;
    chk("flush_acc_ready", 64'(bif0.req_ready), 64'd1);
    cyc();
    bif0.flush = 1'b0; bif0.req_valid = 1'b0;
    chk("flush2_valid", 64'(bif0.rsp_valid), 64'd0);
    bif0.rsp_ready = 1'b1;
    seen = 0;
    for (int c = 0; c < 5; c++) begin
      if (bif0.rsp_valid) seen++;
      cyc();
    end
    chk("flush_no_rsp", 64'(seen), 64'd0);
    read0(32'h4, ri, ra, rf, rok);
    chk("post_flush_instr", 64'(ri), 64'(aw[1]));

    // load/read of the same word in one cycle
    load0(10'd5, aw[5]);
    load_en0 = 1'b1; load_idx0 = 10'd5; load_data0 = 32'hB0B0_B0B0;
    bif0.rsp_ready = 1'b1; bif0.req_valid = 1'b1; bif0.req_addr = 32'h14;
    chk("haz_ready", 64'(bif0.req_ready), 64'd1);
    cyc();
    load_en0 = 1'b0; bif0.req_valid = 1'b0;
    chk("haz_valid", 64'(bif0.rsp_valid), 64'd1);
    chk("haz_old", 64'(bif0.rsp_instr), 64'(aw[5]));
    cyc();
    read0(32'h14, ri, ra, rf, rok);
    chk("haz_new", 64'(ri), 64'h0000_0000_B0B0_B0B0);

    // reset mid-stream on the non-clearing instance
    rst_n1 = 1'b1;
    chk("nc_busy", 64'(init_busy1), 64'd0);
    chk("nc_ready", 64'(bif1.req_ready), 64'd1);
    for (int i = 0; i < 3; i++) begin
      load_en1 = 1'b1; load_idx1 = 10'(i); load_data1 = 32'hC0C0_0000 + 32'(i);
      cyc();
    end
    load_en1 = 1'b0;
    bif1.rsp_ready = 1'b0;
    bif1.req_valid = 1'b1; bif1.req_addr = 32'h0; cyc();
    bif1.req_addr = 32'h4; cyc();
    bif1.req_valid = 1'b0;
    chk("nc_buffered", 64'(bif1.rsp_valid), 64'd1);
    #2 rst_n1 = 1'b0;
    #1;
    chk("nc_rst_valid", 64'(bif1.rsp_valid), 64'd0);
    chk("nc_rst_instr", 64'(bif1.rsp_instr), 64'd0);
    cyc(); cyc();
    rst_n1 = 1'b1;
    chk("nc_rel_ready", 64'(bif1.req_ready), 64'd1);
    chk("nc_rel_valid", 64'(bif1.rsp_valid), 64'd0);
    bif1.rsp_ready = 1'b1;
    bif1.req_valid = 1'b1; bif1.req_addr = 32'h8; cyc();
    bif1.req_addr = 32'h0;
    chk("nc_keep2_valid", 64'(bif1.rsp_valid), 64'd1);
    chk("nc_keep2", 64'(bif1.rsp_instr), 64'hC0C0_0002);
    chk("nc_keep2_addr", 64'(bif1.rsp_addr), 64'd8);
    cyc();
    bif1.req_valid = 1'b0;
    chk("nc_keep0", 64'(bif1.rsp_instr), 64'hC0C0_0000);
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
